fifo_unpackager: RTL and testbench

Splits one wide message of `p_num_concat` packed slices into `p_num_concat` sequential narrow messages, least-significant slice first. It is the inverse of the packaging stage and sits downstream of the async FIFO read side, restoring the original narrow stream. It holds two entries, an active word being emitted plus one pending word, so back-to-back wide words stream out at one slice per cycle with no bubbles.

---
 rtl/fifo_unpackager.sv | 86 ++++++++
 tb/tb_fifo_unpackager.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpackager.sv
// Splits a wide word of p_num_concat slices into sequential narrow slices, LSB slice first; slice 0 valid the cycle after accept.
// Two-entry (active + pending) so words stream bubble-free; req_rdy drops only while both entries are full.
module fifo_unpackager #(
  parameter int p_bit_width  = 3,
  parameter int p_num_concat = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [p_bit_width*p_num_concat-1:0]   req_msg,
  input  logic                                  req_val,
  output logic                                  req_rdy,
  output logic [p_bit_width-1:0]                resp_msg,
  output logic                                  resp_val,
  input  logic                                  resp_rdy,
  output logic                                  resp_last,
  output logic [$clog2(p_num_concat)-1:0]       resp_idx
);

  localparam int IW = $clog2(p_num_concat);
  localparam int WW = p_bit_width * p_num_concat;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [WW-1:0] active;
  logic [WW-1:0] pending;
  logic          req_fire;
  logic          resp_fire;
  logic          at_last;

  // Handshake outputs come from state only; reset merely masks them.
  assign req_rdy   = reset && (state != TWO);
  assign resp_val  = reset && (state != EMPTY);
  assign at_last   = (idx == IW'(p_num_concat - 1));
  assign resp_last = resp_val && at_last;
  assign resp_idx  = idx;
  assign req_fire  = req_val && req_rdy;
  assign resp_fire = resp_val && resp_rdy;

  always_comb begin
    resp_msg = '0;
    for (int i = 0; i < p_num_concat; i++) begin
      if (idx == IW'(i)) resp_msg = active[i*p_bit_width +: p_bit_width];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= EMPTY;
      idx     <= '0;
      active  <= '0;
      pending <= '0;
    end else begin
      if (resp_fire) begin
        if (!at_last) begin
          idx <= idx + IW'(1);
        end else begin
          idx <= '0;
          if (state == TWO) begin
            active <= pending;
            state  <= ONE;
          end else if (req_fire) begin
            active <= req_msg;
          end else begin
            state <= EMPTY;
          end
        end
      end
      // A word arriving on a last-slice fire in ONE was already swapped straight into active above.
      if (req_fire && !(resp_fire && at_last)) begin
        if (state == EMPTY) begin
          active <= req_msg;
          idx    <= '0;
          state  <= ONE;
        end else begin
          pending <= req_msg;
          state   <= TWO;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_unpackager.sv
// Bench for fifo_unpackager: a (3-bit x 2) instance checked against a slice-queue model, plus an (8-bit x 4) instance.
module tb_fifo_unpackager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [5:0]  a_req_msg = '0;
  logic        a_req_val = 1'b0;
  logic        a_req_rdy;
  logic [2:0]  a_resp_msg;
  logic        a_resp_val;
  logic        a_resp_rdy = 1'b0;
  logic        a_resp_last;
  logic [0:0]  a_resp_idx;

  logic [31:0] b_req_msg = '0;
  logic        b_req_val = 1'b0;
  logic        b_req_rdy;
  logic [7:0]  b_resp_msg;
  logic        b_resp_val;
  logic        b_resp_rdy = 1'b0;
  logic        b_resp_last;
  logic [1:0]  b_resp_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_unpackager #(.p_bit_width(3), .p_num_concat(2)) dut_a (
    .clk(clk), .reset(rst_n),
    .req_msg(a_req_msg), .req_val(a_req_val), .req_rdy(a_req_rdy),
    .resp_msg(a_resp_msg), .resp_val(a_resp_val), .resp_rdy(a_resp_rdy),
    .resp_last(a_resp_last), .resp_idx(a_resp_idx)
  );

  fifo_unpackager #(.p_bit_width(8), .p_num_concat(4)) dut_b (
    .clk(clk), .reset(rst_n),
    .req_msg(b_req_msg), .req_val(b_req_val), .req_rdy(b_req_rdy),
    .resp_msg(b_resp_msg), .resp_val(b_resp_val), .resp_rdy(b_resp_rdy),
    .resp_last(b_resp_last), .resp_idx(b_resp_idx)
  );

  // Reference model: queue of slices still owed downstream; words held = ceil(slices / 2).
  typedef struct packed {
    logic [2:0] msg;
    logic       idx;
    logic       last;
  } slice_t;

  slice_t q[$];

  logic [6:0] obs_a;
  assign obs_a = {a_req_rdy, a_resp_val,
                  a_resp_val ? {a_resp_msg, a_resp_idx, a_resp_last} : 5'b0};

  function automatic logic [6:0] exp_a();
    int   held;
    logic e_rdy, e_val;
    held  = (q.size() + 1) / 2;
    e_rdy = rst_n && (held < 2);
    e_val = rst_n && (held > 0);
    return {e_rdy, e_val, e_val ? q[0] : 5'b0};
  endfunction

  // Called just after a negedge: applies inputs, advances the model, returns at the next negedge.
  task automatic drive_a(input logic rv, input logic [5:0] rm, input logic rr, output logic acc);
    int   held;
    logic e_rdy, e_val;
    slice_t s;
    a_req_val  = rv;
    a_req_msg  = rm;
    a_resp_rdy = rr;
    held  = (q.size() + 1) / 2;
    e_rdy = rst_n && (held < 2);
    e_val = rst_n && (held > 0);
    acc   = e_rdy && rv;
    if (e_val && rr) void'(q.pop_front());
    if (acc) begin
      for (int i = 0; i < 2; i++) begin
        s.msg  = rm[i*3 +: 3];
        s.idx  = i[0];
        s.last = (i == 1);
        q.push_back(s);
      end
    end
    @(posedge clk);
    if (!rst_n) q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic acc;
    rst_n = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      drive_a(1'b1, 6'o77, 1'b1, acc);
      n_cmp++;
      if (obs_a !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_a cyc %0d: got %b want %b", c, obs_a, 7'b0);
      end
      n_cmp++;
      if ({b_req_rdy, b_resp_val} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_b cyc %0d: rdy/val got %b want 00", c, {b_req_rdy, b_resp_val});
      end
    end
    a_req_val = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (obs_a !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", obs_a, 7'b1000000);
    end
  endtask

  task automatic test_single_word();
    logic       acc;
    logic [6:0] want [3];
    want[0] = {1'b1, 1'b1, 3'b001, 1'b0, 1'b0};
    want[1] = {1'b1, 1'b1, 3'b010, 1'b1, 1'b1};
    want[2] = {1'b1, 1'b0, 5'b0};
    drive_a(1'b1, 6'b010001, 1'b1, acc);
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (obs_a !== want[c]) begin
        n_fail++;
        $display("FAIL single_word step %0d: got %b want %b", c, obs_a, want[c]);
      end
      drive_a(1'b0, 6'b0, 1'b1, acc);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] words [3];
    logic [2:0] seen [$];
    int         first_c, last_c, sent;
    logic       acc;
    words[0] = 6'o21; words[1] = 6'o43; words[2] = 6'o65;
    sent = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12; c++) begin
      n_cmp++;
      if (obs_a !== exp_a()) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", c, obs_a, exp_a());
      end
      if (a_resp_val) begin
        seen.push_back(a_resp_msg);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      drive_a(sent < 3, sent < 3 ? words[sent] : 6'b0, 1'b1, acc);
      if (acc) sent++;
    end
    n_cmp++;
    if (seen.size() != 6 || last_c - first_c != 5) begin
      n_fail++;
      $display("FAIL back_to_back_stream: got %0d slices over %0d cycles want 6 over 6", seen.size(), last_c - first_c + 1);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (seen[i] !== 3'(i + 1)) begin
          n_fail++;
          $display("FAIL back_to_back_slice %0d: got %0d want %0d", i, seen[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    drive_a(1'b1, 6'o43, 1'b1, acc);
    drive_a(1'b0, 6'b0, 1'b1, acc);
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({a_resp_val, a_resp_msg, a_resp_idx, a_resp_last} !== {1'b1, 3'b100, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL backpressure_hold cyc %0d: val/msg/idx/last got %b want 1_100_1_1", c,
                 {a_resp_val, a_resp_msg, a_resp_idx, a_resp_last});
      end
      if (c > 0) begin
        n_cmp++;
        if (a_req_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL backpressure_full cyc %0d: req_rdy got %b want 0", c, a_req_rdy);
        end
      end
      drive_a(c == 0, 6'o65, 1'b0, acc);
    end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (obs_a !== exp_a()) begin
        n_fail++;
        $display("FAIL backpressure_resume cyc %0d: got %b want %b", c, obs_a, exp_a());
      end
      drive_a(1'b0, 6'b0, 1'b1, acc);
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    drive_a(1'b1, 6'o52, 1'b0, acc);
    drive_a(1'b1, 6'o17, 1'b1, acc);
    n_cmp++;
    if (obs_a !== {1'b0, 1'b1, 3'o5, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got %b want %b", obs_a, {1'b0, 1'b1, 3'o5, 1'b1, 1'b1});
    end
    rst_n = 1'b0;
    drive_a(1'b0, 6'b0, 1'b1, acc);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (obs_a !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_mid_empty: got %b want %b", obs_a, 7'b1000000);
    end
    for (int c = 0; c < 4; c++) begin
      drive_a(1'b0, 6'b0, 1'b1, acc);
      n_cmp++;
      if (a_resp_val !== 1'b0 || obs_a !== exp_a()) begin
        n_fail++;
        $display("FAIL reset_mid_stale cyc %0d: got %b want %b", c, obs_a, exp_a());
      end
    end
  endtask

  task automatic test_wide();
    logic [31:0] w [2];
    logic [10:0] want;
    int          sent, got, k, wi;
    logic        acc;
    w[0] = 32'hDDCCBBAA;
    w[1] = 32'h44332211;
    sent = 0; got = 0;
    for (int c = 0; c < 20 && got < 8; c++) begin
      if (b_resp_val) begin
        k  = got % 4;
        wi = got / 4;
        want = {w[wi][k*8 +: 8], 2'(k), (k == 3)};
        n_cmp++;
        if ({b_resp_msg, b_resp_idx, b_resp_last} !== want) begin
          n_fail++;
          $display("FAIL wide slice %0d: msg/idx/last got %h/%0d/%b want %h/%0d/%b", got,
                   b_resp_msg, b_resp_idx, b_resp_last, want[10:3], want[2:1], want[0]);
        end
        got++;
      end
      b_resp_rdy = 1'b1;
      b_req_val  = (sent < 2);
      b_req_msg  = (sent < 2) ? w[sent] : 32'h0;
      acc = b_req_val && b_req_rdy;
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
    end
    b_req_val = 1'b0;
    n_cmp++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL wide_count: got %0d slices want 8", got);
    end
  endtask

  task automatic test_loopback();
    logic [2:0] in_s [$];
    logic [2:0] out_s [$];
    int         wi, bad, first_bad;
    logic       rv, rr, acc;
    for (int i = 0; i < 1000; i++) in_s.push_back(3'($urandom_range(0, 7)));
    wi = 0;
    for (int c = 0; c < 12000 && out_s.size() < 1000; c++) begin
      n_cmp++;
      if (obs_a !== exp_a()) begin
        n_fail++;
        $display("FAIL loopback cyc %0d: got %b want %b", c, obs_a, exp_a());
      end
      rr = ($urandom_range(0, 3) != 0);
      if (a_resp_val && rr) out_s.push_back(a_resp_msg);
      rv = (wi < 500) && ($urandom_range(0, 2) != 0);
      drive_a(rv, (wi < 500) ? {in_s[2*wi+1], in_s[2*wi]} : 6'b0, rr, acc);
      if (acc) wi++;
    end
    a_req_val = 1'b0;
    n_cmp++;
    if (out_s.size() != 1000) begin
      n_fail++;
      $display("FAIL loopback_count: got %0d slices want 1000", out_s.size());
    end else begin
      bad = 0; first_bad = -1;
      for (int i = 0; i < 1000; i++) begin
        if (out_s[i] !== in_s[i]) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      end
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL loopback_data: %0d wrong slices, first at %0d got %0d want %0d",
                 bad, first_bad, out_s[first_bad], in_s[first_bad]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wide();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
